// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock
module seq_signed_divider #(
    parameter int l = 16
) (
    input  logic         Clock,
    input  logic         ResetN,
    input  logic         Start,
    input  logic         Signed,
    input  logic [l-1:0] Dividend,
    input  logic [l-1:0] Divisor,
    output logic [l-1:0] Quotient,
    output logic [l-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic         Overflow
);
    localparam int cw = $clog2(l);
    typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;
    state_t state, state_nx;
    logic [cw-1:0] cnt;
    logic [l-1:0] quo, rem, dvs, dvd, q_res, r_res;
    logic [l:0] trial;
    logic sign_q, sign_r, zero_f, ovf_f, fit;

    function automatic logic [l-1:0] mag(input logic [l-1:0] x, input logic s);
        return (s & x[l-1]) ? ~x + 1'b1 : x;
    endfunction

    always_ff @(posedge Clock or negedge ResetN)
        if (!ResetN) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE && Start) ? DIVIDE :
                   (state == DIVIDE && cnt == cw'(l-1)) ? FIX :
                   (state == FIX) ? IDLE : state;
        Busy = state != IDLE;
    end

    // trial is the l+1 bit partial remainder after shifting in the next dividend bit
    always_comb begin
        trial = {rem, quo[l-1]};
        fit = trial >= {1'b0, dvs};
        q_res = zero_f ? '1 : ovf_f ? dvd : sign_q ? ~quo + 1'b1 : quo;
        r_res = zero_f ? dvd : ovf_f ? '0 : sign_r ? ~rem + 1'b1 : rem;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            dvd       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_f    <= 1'b0;
            ovf_f     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            Done <= state == FIX;
            if (state == IDLE && Start) begin
                sign_q <= Signed & (Dividend[l-1] ^ Divisor[l-1]);
                sign_r <= Signed & Dividend[l-1];
                quo    <= mag(Dividend, Signed);
                dvs    <= mag(Divisor, Signed);
                dvd    <= Dividend;
                zero_f <= Divisor == '0;
                ovf_f  <= Signed && Dividend == {1'b1, {(l-1){1'b0}}} && Divisor == '1;
                rem    <= '0;
                cnt    <= '0;
            end
            if (state == DIVIDE) begin
                rem <= fit ? l'(trial - {1'b0, dvs}) : l'(trial);
                quo <= {quo[l-2:0], fit};
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                Quotient  <= q_res;
                Remainder <= r_res;
                DivByZero <= zero_f;
                Overflow  <= ~zero_f & ovf_f;
            end
        end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed vectors checked against literals and an arithmetic reference model
module tb_seq_signed_divider;
    logic clk = 0, rst_n = 0, start = 0, sgn = 0;
    logic [15:0] dvd = 0, dvs = 0;
    logic [15:0] quotient, remainder;
    logic busy, done, dz, ov;
    int total = 0, bad = 0, cyc = 0;
    logic m_pend = 0, m_done = 0, m_dz = 0, m_ov = 0, acc = 0;
    logic [15:0] m_q = 0, m_r = 0;
    logic [33:0] m_next = 0;
    int m_at = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(.l(16)) dut (
        .Clock(clk), .ResetN(rst_n), .Start(start), .Signed(sgn),
        .Dividend(dvd), .Divisor(dvs), .Quotient(quotient), .Remainder(remainder),
        .Busy(busy), .Done(done), .DivByZero(dz), .Overflow(ov)
    );

    function automatic logic [33:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        if (b == 0) return {1'b0, 1'b1, 16'hFFFF, a};
        if (s && a == 16'h8000 && b == 16'hFFFF) return {1'b1, 1'b0, 16'h8000, 16'h0000};
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return {2'b00, 16'(sa / sb), 16'(sa % sb)};
        end
        return {2'b00, a / b, a % b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference: one operation in flight from its accepting edge until 17 edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_done = 0; m_q = 0; m_r = 0; m_dz = 0; m_ov = 0;
        end else begin
            cyc++;
            acc = !m_pend && start;
            m_done = m_pend && cyc == m_at;
            if (m_done) begin
                {m_ov, m_dz, m_q, m_r} = m_next;
                m_pend = 0;
            end
            if (acc) begin
                m_next = model(sgn, dvd, dvs);
                m_at = cyc + 17;
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("divbyzero", 32'(dz), 32'(m_dz));
        chk("overflow", 32'(ov), 32'(m_ov));
    end

    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz,
                          input logic eov, input string nm, input bit repulse);
        int n, k;
        sgn = s; dvd = a; dvs = b; start = 1;
        @(negedge clk);
        start = 0; dvd = 16'($urandom); dvs = 16'($urandom);
        n = cyc;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            start = repulse && (cyc == n + 4 || cyc == n + 9);
        end
        start = 0;
        chk({nm, " latency"}, 32'(cyc - n), 32'd17);
        chk({nm, " q"}, 32'(quotient), 32'(eq));
        chk({nm, " r"}, 32'(remainder), 32'(er));
        chk({nm, " dz"}, 32'(dz), 32'(edz));
        chk({nm, " ov"}, 32'(ov), 32'(eov));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset q", 32'(quotient), 0);
        chk("reset busy", 32'(busy), 0);
        rst_n = 1;
        @(negedge clk);
        run_op(1, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0, "s 100/7", 0);
        @(negedge clk);
        run_op(1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 0, 0, "s -100/7", 0);
        @(negedge clk);
        run_op(1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 0, 0, "s 100/-7", 0);
        @(negedge clk);
        run_op(1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, "s ovf", 0);
        @(negedge clk);
        run_op(0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0, 0, "u 8000/ffff", 0);
        @(negedge clk);
        run_op(1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, "s div0", 0);
        @(negedge clk);
        run_op(0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, "u div0", 0);
        @(negedge clk);
        run_op(0, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 0, 0, "u repulse", 1);
        repeat (20) @(negedge clk);
        chk("hold q", 32'(quotient), 32'h7FFF);
        chk("hold r", 32'(remainder), 32'h0001);
        run_op(1, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0, "b2b first", 0);
        run_op(1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 0, 0, "b2b second", 0);
        @(negedge clk);
        sgn = 1; dvd = 16'h7FFF; dvs = 16'h0003; start = 1;
        @(negedge clk);
        start = 0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async q", 32'(quotient), 0);
        chk("async r", 32'(remainder), 0);
        chk("async busy", 32'(busy), 0);
        chk("async done", 32'(done), 0);
        chk("async flags", 32'({dz, ov}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk("no done after reset", 32'(done), 0);
        run_op(1, 16'h7FFF, 16'h0003, 16'h2AAA, 16'h0001, 0, 0, "after reset", 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
